csoc_scan_uart_ctrl: RTL and testbench
======================================

// Module: csoc_scan_uart_ctrl
// PURPOSE
//  UART command engine for CSOC scan test, sitting between the uart rx/tx pair and the CSOC pins.
//  Decodes single-byte ASCII commands to reset, load and unload NCHAINS parallel scan chains, and run functional clocks.
//  Scan data travels as ASCII '0'/'1'; unload inserts a newline every MAX_COLS characters.
// PARAMETERS
//  NCHAINS    1     parallel scan chains, 1..8; bit k of csoc_data_o/csoc_data_i serves chain k
//  CHAIN_LEN  1919  flops per chain = shift cycles per load/unload, 1..4095
//  RUN_CLKS   10    functional CSOC clock pulses issued per 'X', 1..4095
//  RST_CYCLES 16    clk cycles csoc_rstn_o is held low per 'R', 1..255
//  MAX_COLS   70    characters per unload line before '\n', 1..127
// PORTS
//  clk            in   1        system clock; all logic on posedge
//  rstn           in   1        asynchronous, active-low reset
//  rx_data        in   8        received byte
//  new_rx_data    in   1        one-cycle strobe: rx_data valid
//  tx_ready_i     in   1        transmitter idle
//  tx_start_o     out  1        one-cycle transmit request
//  tx_data_o      out  8        byte to transmit; held stable until tx_ready_i rises again
//  leds           out  8        {state[3:0], tm, se, csoc_rstn, busy}
//  csoc_clk_o     out  1        CSOC clock; one-clk-wide high pulses only
//  csoc_rstn_o    out  1        CSOC reset, active low
//  csoc_test_se_o out  1        scan enable
//  csoc_test_tm_o out  1        test mode
//  csoc_data_i    in   NCHAINS  scan-out bits
//  csoc_data_o    out  NCHAINS  scan-in bits
// BEHAVIOUR
//  Reset values: every output 0, leds 0, tm 0, se 0, csoc_rstn_o 0.
//  Reset also forces state IDLE, counters 0, and the chain image undefined. Reset mid-command aborts with no tx.
//  TX handshake (TX_REQ -> TX_WAIT):
//   - TX_REQ: with tx_ready_i=1, drive tx_data_o and pulse tx_start_o for 1 cycle.
//   - TX_WAIT: wait for tx_ready_i=0, then for tx_ready_i=1, then resume the caller state.
//  IDLE: new_rx_data decodes rx_data; new_rx_data outside IDLE/LOAD_RX is ignored.
//  Commands (completion = transmit '.'; unknown byte = transmit '?'):
//   'R': csoc_rstn_o=0 for RST_CYCLES clks, then 1.
//   'T': tm=1.   'N': tm=0.
//   'L': LOAD_RX, se=1.
//     - Collect NCHAINS chars, chain 0 first: '0'/'1' set csoc_data_o[k]; any other byte is skipped.
//     - Then SHIFT: csoc_clk_o high 1 clk, low 1 clk.
//     - Repeat CHAIN_LEN times; se=0; transmit '.'.
//   'U': se=1. Per shift:
//     - Sample csoc_data_i into a register while csoc_clk_o is low.
//     - Transmit NCHAINS chars, chain k='0'+bit k.
//     - Then pulse csoc_clk_o.
//     - col count+1 per char; at MAX_COLS send '\n' and clear col count.
//     - After CHAIN_LEN shifts send '\n', '.'; se=0; col count cleared.
//   'X': se=0; RUN_CLKS pulses of csoc_clk_o (1 high, 1 low clk each).
//  csoc_clk_o never pulses while csoc_rstn_o=0 or outside SHIFT/RUN.
//  Shift counter 12 bit, compares to CHAIN_LEN-1; no wrap.
//  Col counter 7 bit, compares to MAX_COLS-1.
//  busy=1 whenever state!=IDLE.
//  States: IDLE, RST, LOAD_RX, SHIFT, SAMPLE, TX_REQ, TX_WAIT, RUN, DONE.
// STRUCTURE
//  csoc_test_pkg holds:
//   - state encoding;
//   - command byte constants 'R','T','N','L','U','X';
//   - response constants '.','?','\n'.
//  Sub-module uart_tx_hs: the TX_REQ/TX_WAIT handshake, with a byte+valid in / done out interface.
// TESTING
//  1. Reset, 'R' -> csoc_rstn_o low exactly 16 clks, then high; tx '.'; no csoc_clk_o pulse.
//  2. CHAIN_LEN=8: 'L' + "10110011" -> csoc_data_o at the 8 pulses = 1,0,1,1,0,0,1,1 with se=1; tx '.'.
//  3. CHAIN_LEN=8, MAX_COLS=3, csoc_data_i pattern 1,1,0,... -> 'U' tx "110\n" ... "\n."; exactly 8 pulses.
//  4. 'X' with RUN_CLKS=10 -> 10 csoc_clk_o pulses, se=0; tx '.'.
//  5. 'Z' -> tx '?', state IDLE. Bytes received during 'U' -> ignored, output unchanged.
//  6. rstn low mid-'L' after 3 shifts -> all outputs 0 in the same cycle; the next 'U' proceeds normally.

Source files
------------

// File: rtl/csoc_scan_uart_ctrl_pkg.sv
// Shared types and byte constants for the CSOC scan UART command engine.
package csoc_scan_uart_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RST     = 4'd1,
        ST_LOAD_RX = 4'd2,
        ST_SHIFT   = 4'd3,
        ST_SAMPLE  = 4'd4,
        ST_TX_REQ  = 4'd5,
        ST_TX_WAIT = 4'd6,
        ST_RUN     = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        HS_IDLE      = 2'd0,
        HS_WAIT_LOW  = 2'd1,
        HS_WAIT_HIGH = 2'd2
    } hs_state_t;

    localparam logic [7:0] CMD_RST    = 8'h52;  // 'R'
    localparam logic [7:0] CMD_TM_ON  = 8'h54;  // 'T'
    localparam logic [7:0] CMD_TM_OFF = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_LOAD   = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_UNLOAD = 8'h55;  // 'U'
    localparam logic [7:0] CMD_RUN    = 8'h58;  // 'X'

    localparam logic [7:0] RSP_DONE   = 8'h2E;  // '.'
    localparam logic [7:0] RSP_UNK    = 8'h3F;  // '?'
    localparam logic [7:0] RSP_NL     = 8'h0A;  // '\n'

    localparam logic [7:0] CH_0       = 8'h30;  // '0'
    localparam logic [7:0] CH_1       = 8'h31;  // '1'

    function automatic logic is_bit_char(input logic [7:0] b);
        return (b == CH_0) || (b == CH_1);
    endfunction

endpackage

// File: rtl/csoc_scan_uart_ctrl_if.sv
// UART-side byte bus: receive strobe/data in, transmit request/data out.
interface csoc_scan_uart_ctrl_if;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       tx_ready_i;
    logic       tx_start_o;
    logic [7:0] tx_data_o;

    modport slave  (input  rx_data, new_rx_data, tx_ready_i,
                    output tx_start_o, tx_data_o);
    modport master (output rx_data, new_rx_data, tx_ready_i,
                    input  tx_start_o, tx_data_o);
endinterface

// File: rtl/csoc_scan_uart_ctrl_tx_hs.sv
// Transmit handshake: launch one byte when the transmitter is idle, then
// report done once the transmitter has gone busy and returned to idle.
module uart_tx_hs
    import csoc_scan_uart_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_req,
    input  logic [7:0] i_byte,
    input  logic       i_tx_ready,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_done
);

    hs_state_t  r_state;
    logic       r_start;
    logic [7:0] r_data;
    logic       r_done;

    // Handshake sequencer; tx data is held until the next launch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= HS_IDLE;
            r_start <= 1'b0;
            r_data  <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                HS_IDLE: begin
                    if (i_req && i_tx_ready) begin
                        r_start <= 1'b1;
                        r_data  <= i_byte;
                        r_state <= HS_WAIT_LOW;
                    end
                end
                HS_WAIT_LOW: begin
                    if (!i_tx_ready) r_state <= HS_WAIT_HIGH;
                end
                HS_WAIT_HIGH: begin
                    if (i_tx_ready) begin
                        r_done  <= 1'b1;
                        r_state <= HS_IDLE;
                    end
                end
                default: r_state <= HS_IDLE;
            endcase
        end
    end

    assign o_tx_start = r_start;
    assign o_tx_data  = r_data;
    assign o_done     = r_done;

endmodule

// File: rtl/csoc_scan_uart_ctrl.sv
// UART command engine for CSOC scan test.
//
// state      | meaning
// IDLE       | waiting for a command byte
// RST        | holding csoc_rstn_o low
// LOAD_RX    | collecting one '0'/'1' per chain for the next shift
// SHIFT      | one csoc_clk_o pulse (high clk, low clk)
// SAMPLE     | capture scan-out bits, emit them (and line breaks)
// TX_REQ     | byte handed to the transmit handshake
// TX_WAIT    | waiting for the transmitter to finish, then resume r_ret
// RUN        | functional clock pulses
// DONE       | queue the '.' completion byte
module csoc_scan_uart_ctrl
    import csoc_scan_uart_ctrl_pkg::*;
#(
    parameter int NCHAINS    = 1,
    parameter int CHAIN_LEN  = 1919,
    parameter int RUN_CLKS   = 10,
    parameter int RST_CYCLES = 16,
    parameter int MAX_COLS   = 70
) (
    input  logic                    clk,
    input  logic                    rstn,
    csoc_scan_uart_ctrl_if.slave    io_uart,
    output logic [7:0]              leds,
    output logic                    csoc_clk_o,
    output logic                    csoc_rstn_o,
    output logic                    csoc_test_se_o,
    output logic                    csoc_test_tm_o,
    input  logic [NCHAINS-1:0]      csoc_data_i,
    output logic [NCHAINS-1:0]      csoc_data_o
);

    localparam logic [11:0] LAST_SHIFT = 12'(CHAIN_LEN - 1);
    localparam logic [11:0] LAST_RUN   = 12'(RUN_CLKS - 1);
    localparam logic [11:0] LAST_RST   = 12'(RST_CYCLES - 1);
    localparam logic [6:0]  LAST_COL   = 7'(MAX_COLS - 1);
    localparam logic [3:0]  LAST_CHAIN = 4'(NCHAINS - 1);
    localparam logic [3:0]  NUM_CHAIN  = 4'(NCHAINS);

    state_t               r_state;
    state_t               r_ret;
    logic [7:0]           r_tx_byte;
    logic                 r_tm;
    logic                 r_se;
    logic                 r_csoc_rstn;
    logic                 r_csoc_clk;
    logic [NCHAINS-1:0]   r_data_o;
    logic [NCHAINS-1:0]   r_sample;
    logic [11:0]          r_cnt;
    logic [6:0]           r_col;
    logic [3:0]           r_idx;
    logic                 r_ph;
    logic                 r_unload;
    logic                 r_nl_pend;

    logic                 w_tx_req;
    logic                 w_tx_start;
    logic [7:0]           w_tx_data;
    logic                 w_tx_done;
    logic                 w_sel_bit;

    assign w_tx_req = (r_state == ST_TX_REQ);

    uart_tx_hs u_tx_hs (
        .clk        (clk),
        .rstn       (rstn),
        .i_req      (w_tx_req),
        .i_byte     (r_tx_byte),
        .i_tx_ready (io_uart.tx_ready_i),
        .o_tx_start (w_tx_start),
        .o_tx_data  (w_tx_data),
        .o_done     (w_tx_done)
    );

    // Select the captured scan-out bit of the chain currently being printed.
    always_comb begin
        w_sel_bit = 1'b0;
        for (int k = 0; k < NCHAINS; k++) begin
            if (r_idx == 4'(k)) w_sel_bit = r_sample[k];
        end
    end

    // Command FSM with registered CSOC-side outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_ret       <= ST_IDLE;
            r_tx_byte   <= 8'h00;
            r_tm        <= 1'b0;
            r_se        <= 1'b0;
            r_csoc_rstn <= 1'b0;
            r_csoc_clk  <= 1'b0;
            r_data_o    <= '0;
            r_sample    <= '0;
            r_cnt       <= 12'd0;
            r_col       <= 7'd0;
            r_idx       <= 4'd0;
            r_ph        <= 1'b0;
            r_unload    <= 1'b0;
            r_nl_pend   <= 1'b0;
        end else begin
            r_csoc_clk <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_uart.new_rx_data) begin
                        r_cnt <= 12'd0;
                        r_ph  <= 1'b0;
                        r_idx <= 4'd0;
                        case (io_uart.rx_data)
                            CMD_RST: begin
                                r_csoc_rstn <= 1'b0;
                                r_state     <= ST_RST;
                            end
                            CMD_TM_ON: begin
                                r_tm    <= 1'b1;
                                r_state <= ST_DONE;
                            end
                            CMD_TM_OFF: begin
                                r_tm    <= 1'b0;
                                r_state <= ST_DONE;
                            end
                            CMD_LOAD: begin
                                r_se     <= 1'b1;
                                r_unload <= 1'b0;
                                r_state  <= ST_LOAD_RX;
                            end
                            CMD_UNLOAD: begin
                                r_se      <= 1'b1;
                                r_unload  <= 1'b1;
                                r_col     <= 7'd0;
                                r_nl_pend <= 1'b0;
                                r_state   <= ST_SAMPLE;
                            end
                            CMD_RUN: begin
                                r_se    <= 1'b0;
                                r_state <= ST_RUN;
                            end
                            default: begin
                                r_tx_byte <= RSP_UNK;
                                r_ret     <= ST_IDLE;
                                r_state   <= ST_TX_REQ;
                            end
                        endcase
                    end
                end
                ST_RST: begin
                    if (r_cnt == LAST_RST) begin
                        r_csoc_rstn <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                    end
                end
                ST_LOAD_RX: begin
                    if (io_uart.new_rx_data && is_bit_char(io_uart.rx_data)) begin
                        for (int k = 0; k < NCHAINS; k++) begin
                            if (r_idx == 4'(k)) r_data_o[k] <= (io_uart.rx_data == CH_1);
                        end
                        if (r_idx == LAST_CHAIN) begin
                            r_idx   <= 4'd0;
                            r_ph    <= 1'b0;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!r_ph) begin
                        // no pulse reaches the CSOC while it is held in reset
                        r_csoc_clk <= r_csoc_rstn;
                        r_ph       <= 1'b1;
                    end else begin
                        r_ph <= 1'b0;
                        if (r_cnt == LAST_SHIFT) begin
                            r_cnt <= 12'd0;
                            if (r_unload) begin
                                r_col     <= 7'd0;
                                r_tx_byte <= RSP_NL;
                                r_ret     <= ST_DONE;
                                r_state   <= ST_TX_REQ;
                            end else begin
                                r_state <= ST_DONE;
                            end
                        end else begin
                            r_cnt   <= r_cnt + 12'd1;
                            r_state <= r_unload ? ST_SAMPLE : ST_LOAD_RX;
                        end
                    end
                end
                ST_SAMPLE: begin
                    if (!r_ph) begin
                        r_sample <= csoc_data_i;
                        r_idx    <= 4'd0;
                        r_ph     <= 1'b1;
                    end else if (r_nl_pend) begin
                        r_nl_pend <= 1'b0;
                        r_col     <= 7'd0;
                        r_tx_byte <= RSP_NL;
                        r_ret     <= ST_SAMPLE;
                        r_state   <= ST_TX_REQ;
                    end else if (r_idx == NUM_CHAIN) begin
                        r_ph    <= 1'b0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_tx_byte <= w_sel_bit ? CH_1 : CH_0;
                        r_idx     <= r_idx + 4'd1;
                        r_col     <= r_col + 7'd1;
                        if (r_col == LAST_COL) r_nl_pend <= 1'b1;
                        r_ret     <= ST_SAMPLE;
                        r_state   <= ST_TX_REQ;
                    end
                end
                ST_RUN: begin
                    if (!r_ph) begin
                        r_csoc_clk <= r_csoc_rstn;
                        r_ph       <= 1'b1;
                    end else begin
                        r_ph <= 1'b0;
                        if (r_cnt == LAST_RUN) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 12'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_se      <= 1'b0;
                    r_unload  <= 1'b0;
                    r_tx_byte <= RSP_DONE;
                    r_ret     <= ST_IDLE;
                    r_state   <= ST_TX_REQ;
                end
                ST_TX_REQ: begin
                    if (w_tx_start) r_state <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (w_tx_done) r_state <= r_ret;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_uart.tx_start_o = w_tx_start;
    assign io_uart.tx_data_o  = w_tx_data;
    assign leds               = {r_state, r_tm, r_se, r_csoc_rstn, (r_state != ST_IDLE)};
    assign csoc_clk_o         = r_csoc_clk;
    assign csoc_rstn_o        = r_csoc_rstn;
    assign csoc_test_se_o     = r_se;
    assign csoc_test_tm_o     = r_tm;
    assign csoc_data_o        = r_data_o;

endmodule

// File: tb/tb_csoc_scan_uart_ctrl.sv
// Directed bench for the CSOC scan UART command engine.
module tb_csoc_scan_uart_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] leds;
    logic       csoc_clk_o, csoc_rstn_o, csoc_test_se_o, csoc_test_tm_o;
    logic [0:0] csoc_data_i;
    logic [0:0] csoc_data_o;

    int checks = 0;
    int failures = 0;

    int         pulses = 0;
    int         clk_in_rst = 0;
    int         wide = 0;
    int         bad_start = 0;
    int         tx_busy = 0;
    int         upos = 0;
    logic       prev_clk = 1'b0;
    logic       pq[$];
    logic       sq[$];
    logic [7:0] txq[$];
    logic [7:0] upat = 8'b11010011;

    always #5 clk = ~clk;

    csoc_scan_uart_ctrl_if bus ();

    csoc_scan_uart_ctrl #(
        .NCHAINS(1), .CHAIN_LEN(8), .RUN_CLKS(10), .RST_CYCLES(16), .MAX_COLS(3)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .io_uart        (bus),
        .leds           (leds),
        .csoc_clk_o     (csoc_clk_o),
        .csoc_rstn_o    (csoc_rstn_o),
        .csoc_test_se_o (csoc_test_se_o),
        .csoc_test_tm_o (csoc_test_tm_o),
        .csoc_data_i    (csoc_data_i),
        .csoc_data_o    (csoc_data_o)
    );

    // Transmitter model, CSOC pulse monitor and scan-out pattern source.
    always @(negedge clk) begin
        if (bus.tx_start_o) begin
            if (bus.tx_ready_i !== 1'b1) bad_start++;
            txq.push_back(bus.tx_data_o);
            bus.tx_ready_i = 1'b0;
            tx_busy = 3;
        end else if (tx_busy > 0) begin
            tx_busy--;
        end else begin
            bus.tx_ready_i = 1'b1;
        end
        if (csoc_clk_o) begin
            pulses++;
            pq.push_back(csoc_data_o[0]);
            sq.push_back(csoc_test_se_o);
            if (!csoc_rstn_o) clk_in_rst++;
            if (prev_clk) wide++;
        end
        prev_clk = csoc_clk_o;
        if (!csoc_test_se_o) upos = 0;
        else if (csoc_clk_o) upos++;
        csoc_data_i[0] = (upos < 8) ? upat[7 - upos] : 1'b0;
    end

    function automatic string tx_since(input int from);
        string s = "";
        for (int i = from; i < txq.size(); i++) s = $sformatf("%s%c", s, txq[i]);
        return s;
    endfunction

    function automatic string vis(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) r = {r, "\\n"};
            else r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.new_rx_data = 1'b1;
        @(negedge clk);
        bus.new_rx_data = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (leds[0] && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_state(input logic [3:0] st, input int budget);
        int n = 0;
        while (leds[7:4] !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (leds !== 8'h00) begin
            $display("FAIL reset_leds: got %h want 00", leds); failures++;
        end
        checks++;
        if ({bus.tx_start_o, bus.tx_data_o} !== 9'h000) begin
            $display("FAIL reset_tx: got start=%b data=%h want 0/00", bus.tx_start_o, bus.tx_data_o); failures++;
        end
        checks++;
        if ({csoc_clk_o, csoc_rstn_o, csoc_test_se_o, csoc_test_tm_o, csoc_data_o} !== 5'b0) begin
            $display("FAIL reset_csoc: got clk/rstn/se/tm/data=%b%b%b%b%b want 00000",
                     csoc_clk_o, csoc_rstn_o, csoc_test_se_o, csoc_test_tm_o, csoc_data_o); failures++;
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rst_cmd();
        int t0, p0, low, n;
        t0 = txq.size();
        send_byte("R");
        wait_idle(200);
        checks++;
        if (csoc_rstn_o !== 1'b1 || leds[0] !== 1'b0) begin
            $display("FAIL rst_first: got rstn=%b busy=%b want 1/0", csoc_rstn_o, leds[0]); failures++;
        end
        t0 = txq.size();
        p0 = pulses;
        send_byte("R");
        low = 0;
        n = 0;
        while (n < 200) begin
            if (!csoc_rstn_o) low++;
            if (!leds[0]) break;
            @(negedge clk);
            n++;
        end
        checks++;
        if (low != 16) begin
            $display("FAIL rst_low_cycles: got %0d want 16", low); failures++;
        end
        checks++;
        if (leds[0] !== 1'b0 || csoc_rstn_o !== 1'b1) begin
            $display("FAIL rst_end: got busy=%b rstn=%b want 0/1", leds[0], csoc_rstn_o); failures++;
        end
        checks++;
        if (tx_since(t0) != ".") begin
            $display("FAIL rst_tx: got \"%s\" want \".\"", vis(tx_since(t0))); failures++;
        end
        checks++;
        if (pulses != p0) begin
            $display("FAIL rst_pulses: got %0d want 0", pulses - p0); failures++;
        end
    endtask

    task automatic test_tm();
        int t0;
        t0 = txq.size();
        send_byte("T");
        wait_idle(200);
        checks++;
        if (csoc_test_tm_o !== 1'b1 || leds[3] !== 1'b1) begin
            $display("FAIL tm_on: got tm=%b led=%b want 1/1", csoc_test_tm_o, leds[3]); failures++;
        end
        send_byte("N");
        wait_idle(200);
        checks++;
        if (csoc_test_tm_o !== 1'b0 || leds[3] !== 1'b0) begin
            $display("FAIL tm_off: got tm=%b led=%b want 0/0", csoc_test_tm_o, leds[3]); failures++;
        end
        checks++;
        if (tx_since(t0) != "..") begin
            $display("FAIL tm_tx: got \"%s\" want \"..\"", vis(tx_since(t0))); failures++;
        end
    endtask

    task automatic test_load();
        int t0, p0, se_ones;
        string lc;
        logic [7:0] got;
        t0 = txq.size();
        p0 = pulses;
        lc = "a10110011";
        send_byte("L");
        for (int i = 0; i < lc.len(); i++) begin
            wait_state(4'd2, 100);
            checks++;
            if (leds[7:4] !== 4'd2) begin
                $display("FAIL load_rx_wait: char %0d state=%0d want 2", i, leds[7:4]); failures++;
            end
            send_byte(lc[i]);
        end
        wait_idle(500);
        checks++;
        if (leds[0] !== 1'b0) begin
            $display("FAIL load_idle: got busy=%b want 0", leds[0]); failures++;
        end
        checks++;
        if (pulses - p0 != 8) begin
            $display("FAIL load_pulses: got %0d want 8", pulses - p0); failures++;
        end
        got = 8'h00;
        se_ones = 0;
        for (int i = p0; i < pulses && i < p0 + 8; i++) begin
            got = {got[6:0], pq[i]};
            if (sq[i]) se_ones++;
        end
        checks++;
        if (got !== 8'b10110011) begin
            $display("FAIL load_data: got %b want 10110011", got); failures++;
        end
        checks++;
        if (se_ones != 8 || csoc_test_se_o !== 1'b0) begin
            $display("FAIL load_se: got se-high pulses=%0d se_now=%b want 8/0", se_ones, csoc_test_se_o); failures++;
        end
        checks++;
        if (tx_since(t0) != ".") begin
            $display("FAIL load_tx: got \"%s\" want \".\"", vis(tx_since(t0))); failures++;
        end
    endtask

    task automatic test_unload_ignore();
        int t0, p0, se_ones;
        t0 = txq.size();
        p0 = pulses;
        send_byte("U");
        repeat (15) @(negedge clk);
        send_byte("X");
        send_byte("R");
        send_byte("L");
        wait_idle(2000);
        checks++;
        if (leds[0] !== 1'b0) begin
            $display("FAIL unload_idle: got busy=%b want 0", leds[0]); failures++;
        end
        checks++;
        if (tx_since(t0) != "110\n100\n11\n.") begin
            $display("FAIL unload_tx: got \"%s\" want \"110\\n100\\n11\\n.\"", vis(tx_since(t0))); failures++;
        end
        checks++;
        if (pulses - p0 != 8) begin
            $display("FAIL unload_pulses: got %0d want 8", pulses - p0); failures++;
        end
        se_ones = 0;
        for (int i = p0; i < pulses; i++) if (sq[i]) se_ones++;
        checks++;
        if (se_ones != 8 || csoc_test_se_o !== 1'b0) begin
            $display("FAIL unload_se: got se-high pulses=%0d se_now=%b want 8/0", se_ones, csoc_test_se_o); failures++;
        end
        checks++;
        if (csoc_rstn_o !== 1'b1 || csoc_test_tm_o !== 1'b0) begin
            $display("FAIL unload_ignored_cmds: got rstn=%b tm=%b want 1/0", csoc_rstn_o, csoc_test_tm_o); failures++;
        end
    endtask

    task automatic test_run();
        int t0, p0, se_ones;
        t0 = txq.size();
        p0 = pulses;
        send_byte("X");
        wait_idle(500);
        checks++;
        if (pulses - p0 != 10) begin
            $display("FAIL run_pulses: got %0d want 10", pulses - p0); failures++;
        end
        se_ones = 0;
        for (int i = p0; i < pulses; i++) if (sq[i]) se_ones++;
        checks++;
        if (se_ones != 0) begin
            $display("FAIL run_se: got se-high pulses=%0d want 0", se_ones); failures++;
        end
        checks++;
        if (tx_since(t0) != ".") begin
            $display("FAIL run_tx: got \"%s\" want \".\"", vis(tx_since(t0))); failures++;
        end
    endtask

    task automatic test_unknown();
        int t0, p0;
        t0 = txq.size();
        p0 = pulses;
        send_byte("Z");
        wait_idle(200);
        checks++;
        if (tx_since(t0) != "?") begin
            $display("FAIL unknown_tx: got \"%s\" want \"?\"", vis(tx_since(t0))); failures++;
        end
        checks++;
        if (leds[7:4] !== 4'd0 || pulses != p0) begin
            $display("FAIL unknown_state: got state=%0d pulses=%0d want 0/0", leds[7:4], pulses - p0); failures++;
        end
    endtask

    task automatic test_reset_mid_load();
        int t0, p0, p1;
        string lc;
        t0 = txq.size();
        p0 = pulses;
        lc = "101";
        send_byte("L");
        for (int i = 0; i < lc.len(); i++) begin
            wait_state(4'd2, 100);
            send_byte(lc[i]);
        end
        wait_state(4'd2, 100);
        checks++;
        if (pulses - p0 != 3 || csoc_data_o !== 1'b1 || csoc_test_se_o !== 1'b1) begin
            $display("FAIL midload_pre: got pulses=%0d data=%b se=%b want 3/1/1", pulses - p0, csoc_data_o, csoc_test_se_o); failures++;
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (leds !== 8'h00 || {csoc_clk_o, csoc_rstn_o, csoc_test_se_o, csoc_test_tm_o, csoc_data_o} !== 5'b0
            || bus.tx_start_o !== 1'b0 || bus.tx_data_o !== 8'h00) begin
            $display("FAIL midload_reset: got leds=%h clk/rstn/se/tm/data=%b%b%b%b%b tx=%b/%h want all 0",
                     leds, csoc_clk_o, csoc_rstn_o, csoc_test_se_o, csoc_test_tm_o, csoc_data_o,
                     bus.tx_start_o, bus.tx_data_o); failures++;
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (txq.size() != t0) begin
            $display("FAIL midload_no_tx: got %0d bytes want 0", txq.size() - t0); failures++;
        end
        send_byte("R");
        wait_idle(200);
        p1 = pulses;
        send_byte("U");
        wait_idle(2000);
        checks++;
        if (tx_since(t0) != ".110\n100\n11\n.") begin
            $display("FAIL after_reset_unload_tx: got \"%s\" want \".110\\n100\\n11\\n.\"", vis(tx_since(t0))); failures++;
        end
        checks++;
        if (pulses - p1 != 8) begin
            $display("FAIL after_reset_unload_pulses: got %0d want 8", pulses - p1); failures++;
        end
        checks++;
        if (clk_in_rst != 0 || wide != 0 || bad_start != 0) begin
            $display("FAIL pin_rules: got clk-in-reset=%0d wide-pulses=%0d bad-starts=%0d want 0/0/0",
                     clk_in_rst, wide, bad_start); failures++;
        end
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.new_rx_data = 1'b0;
        test_reset();
        test_rst_cmd();
        test_tm();
        test_load();
        test_unload_ignore();
        test_run();
        test_unknown();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
